fpu_issue_arbiter: RTL and testbench

//  Shares one pipelined fpu core among NREQ requesters. Round-robin arbitration and issue of one

---
 rtl/fpu_issue_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_fpu_issue_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_issue_arbiter
//
// Shares one pipelined FPU core among NREQ requesters. Each cycle a round-robin
// arbiter picks at most one requester with a legal op code (add/sub/mul/div).
// Its operands are registered towards the core, and a {valid,id} tag follows
// the op down a shadow pipe that matches the core latency. When the tag comes
// out, the core result and exception flags are registered. They are returned
// to the issuing requester as a one-cycle rsp_valid pulse. Per-requester
// sticky flags accumulate the exception flags until that requester clears them.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   en              1 = new grants allowed; 0 = in-flight ops drain only
//   req_valid/ready per-requester handshake (ready is a one-hot grant)
//   req_opa/opb     32-bit operands, slice i = [32*i +: 32]
//   req_op/rmode    3-bit op code / 2-bit rounding mode per requester
//   fpu_opa/opb/op/rmode   registered operands driven into the core
//   fpu_out/flags   core result and {inf,snan,qnan,ine,ovf,unf,zero,dbz}
//   rsp_valid       one-hot completion pulse
//   rsp_data/flags  result and flags, held while rsp_valid = 0
//   sticky_flags    per-requester OR of rsp_flags since the last flag_clr
//   flag_clr        per-requester sticky clear
//   busy            any op in the tag pipe or the response stage
// -----------------------------------------------------------------------------
module fpu_issue_arbiter #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 4,
    parameter int IDW     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_opa,
    input  logic [NREQ*32-1:0]   req_opb,
    input  logic [NREQ*3-1:0]    req_op,
    input  logic [NREQ*2-1:0]    req_rmode,
    output logic [31:0]          fpu_opa,
    output logic [31:0]          fpu_opb,
    output logic [2:0]           fpu_op,
    output logic [1:0]           fpu_rmode,
    input  logic [31:0]          fpu_out,
    input  logic [7:0]           fpu_flags,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_data,
    output logic [7:0]           rsp_flags,
    output logic [NREQ*8-1:0]    sticky_flags,
    input  logic [NREQ-1:0]      flag_clr,
    output logic                 busy
);

    // Per-requester views of the flattened operand buses.
    logic [NREQ-1:0] w_eligible;
    logic [31:0]     w_opa_arr   [NREQ];
    logic [31:0]     w_opb_arr   [NREQ];
    logic [2:0]      w_op_arr    [NREQ];
    logic [1:0]      w_rmode_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign w_opa_arr[gi]   = req_opa[32*gi +: 32];
            assign w_opb_arr[gi]   = req_opb[32*gi +: 32];
            assign w_op_arr[gi]    = req_op[3*gi +: 3];
            assign w_rmode_arr[gi] = req_rmode[2*gi +: 2];
            // Illegal op codes are never granted; the requester simply stalls.
            assign w_eligible[gi]  = req_valid[gi] & (req_op[3*gi +: 3] <= 3'd3);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Round-robin grant
    // ------------------------------------------------------------------------
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  w_gid;
    logic            w_found;
    logic [NREQ-1:0] w_grant;
    logic            w_hs;

    // (base + k) mod NREQ without relying on NREQ being a power of two.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    always_comb begin
        w_gid   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_eligible[rr_index(r_ptr, k)]) begin
                w_found = 1'b1;
                w_gid   = rr_index(r_ptr, k);
            end
        end
    end

    assign w_grant   = (w_found && en && !rst) ? (NREQ'(1) << w_gid) : '0;
    assign req_ready = w_grant;
    // The grant only ever lands on a valid requester, so any grant is a handshake.
    assign w_hs      = |w_grant;

    // ------------------------------------------------------------------------
    // Issue: pointer and operand registers
    // ------------------------------------------------------------------------
    logic [31:0] r_fpu_opa;
    logic [31:0] r_fpu_opb;
    logic [2:0]  r_fpu_op;
    logic [1:0]  r_fpu_rmode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_fpu_opa   <= '0;
            r_fpu_opb   <= '0;
            r_fpu_op    <= '0;
            r_fpu_rmode <= '0;
        end else if (w_hs) begin
            r_ptr       <= (int'(w_gid) == NREQ - 1) ? '0 : w_gid + 1'b1;
            r_fpu_opa   <= w_opa_arr[w_gid];
            r_fpu_opb   <= w_opb_arr[w_gid];
            r_fpu_op    <= w_op_arr[w_gid];
            r_fpu_rmode <= w_rmode_arr[w_gid];
        end
    end

    assign fpu_opa   = r_fpu_opa;
    assign fpu_opb   = r_fpu_opb;
    assign fpu_op    = r_fpu_op;
    assign fpu_rmode = r_fpu_rmode;

    // ------------------------------------------------------------------------
    // Shadow tag pipe. Stage 0 loads on the same edge as the operand register,
    // so stage LATENCY holds the tag exactly while fpu_out is valid for it;
    // the response register then captures on the following edge.
    // ------------------------------------------------------------------------
    logic [LATENCY:0] r_tag_v;
    logic [IDW-1:0]   r_tag_id [LATENCY+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v <= '0;
        end else begin
            r_tag_v <= {r_tag_v[LATENCY-1:0], w_hs};
        end
        // Ids need no reset: they are only looked at alongside a valid bit.
        r_tag_id[0] <= w_gid;
        for (int k = 1; k <= LATENCY; k++) begin
            r_tag_id[k] <= r_tag_id[k-1];
        end
    end

    // ------------------------------------------------------------------------
    // Response stage and sticky flags
    // ------------------------------------------------------------------------
    logic [NREQ-1:0]   w_rsp_valid_next;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [31:0]       r_rsp_data;
    logic [7:0]        r_rsp_flags;
    logic [NREQ*8-1:0] r_sticky;
    logic [NREQ*8-1:0] w_sticky_next;

    assign w_rsp_valid_next = r_tag_v[LATENCY] ? (NREQ'(1) << r_tag_id[LATENCY]) : '0;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_sticky
            // Clear first, then OR in the new flags, so a same-cycle set survives.
            assign w_sticky_next[8*gi +: 8] =
                (flag_clr[gi] ? 8'h00 : r_sticky[8*gi +: 8]) |
                (w_rsp_valid_next[gi] ? fpu_flags : 8'h00);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
            r_sticky    <= '0;
        end else begin
            r_rsp_valid <= w_rsp_valid_next;
            r_sticky    <= w_sticky_next;
            if (r_tag_v[LATENCY]) begin
                r_rsp_data  <= fpu_out;
                r_rsp_flags <= fpu_flags;
            end
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_flags    = r_rsp_flags;
    assign sticky_flags = r_sticky;
    assign busy         = (|r_tag_v) | (|r_rsp_valid);

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
module tb_fpu_issue_arbiter;
    localparam int NREQ = 4;
    localparam int LAT  = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, en;
    logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, flag_clr;
    logic [NREQ*32-1:0] req_opa, req_opb;
    logic [NREQ*3-1:0] req_op;
    logic [NREQ*2-1:0] req_rmode;
    logic [31:0]       fpu_opa, fpu_opb, fpu_out, rsp_data;
    logic [2:0]        fpu_op;
    logic [1:0]        fpu_rmode;
    logic [7:0]        fpu_flags, rsp_flags;
    logic [NREQ*8-1:0] sticky_flags;
    logic              busy;

    fpu_issue_arbiter #(.NREQ(NREQ), .LATENCY(LAT), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opa(req_opa), .req_opb(req_opb), .req_op(req_op), .req_rmode(req_rmode),
        .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_op(fpu_op), .fpu_rmode(fpu_rmode),
        .fpu_out(fpu_out), .fpu_flags(fpu_flags),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .sticky_flags(sticky_flags), .flag_clr(flag_clr), .busy(busy)
    );

    // Stand-in FPU core: fixed answers for the IEEE vectors used here, a
    // scrambling function otherwise (flags = low byte of opb).
    function automatic logic [39:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op, input logic [1:0] rm);
        if (a == 32'h3F800000 && b == 32'h40000000 && op == 3'd0) return {8'h00, 32'h40400000};
        if (a == 32'h7F800000 && b == 32'h7FC00000) return {8'hA0, 32'h7FC00000};
        return {b[7:0], (a ^ {b[15:0], b[31:16]}) + {27'd0, op, rm}};
    endfunction

    logic [39:0] core_pipe [LAT];
    always @(posedge clk) begin
        core_pipe[0] <= core_fn(fpu_opa, fpu_opb, fpu_op, fpu_rmode);
        for (int k = 1; k < LAT; k++) core_pipe[k] <= core_pipe[k-1];
    end
    assign fpu_out   = core_pipe[LAT-1][31:0];
    assign fpu_flags = core_pipe[LAT-1][39:32];

    typedef struct { logic [31:0] opa; logic [31:0] opb; logic [2:0] op; logic [1:0] rm; } op_t;
    typedef struct { int id; logic [31:0] data; logic [7:0] flags; int due; } exp_t;
    typedef struct { int req; logic [31:0] opa; logic [31:0] opb; logic [2:0] op; logic [1:0] rm; } vec_t;

    op_t  pend [NREQ][$];
    exp_t sb[$];
    int   grant_log[$];
    vec_t vecs [12];

    int s = 0, n_checks = 0, n_pass = 0, hs_count = 0, last_hs_step = 0, m_ptr = 0;
    logic tb_rst = 1'b1, tb_en = 1'b1, prev_rst = 1'b0;
    logic [NREQ-1:0] tb_clr = '0, prev_clr = '0;
    logic [7:0]  m_sticky [NREQ];
    logic [31:0] m_last_data = '0;
    logic [7:0]  m_last_flags = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (step %0d)", name, act, exp, s);
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        $display("FAIL %s: bound expired, got not-done expected done (step %0d)", name, s);
    endtask

    // Compare the registered outputs produced by the previous edge.
    task automatic check_rsp();
        logic [NREQ-1:0] oh;
        logic            rsp_now;
        exp_t            e;
        rsp_now = 1'b0;
        if (prev_rst) begin
            sb.delete();
            for (int i = 0; i < NREQ; i++) m_sticky[i] = 8'h00;
            m_last_data = '0; m_last_flags = '0;
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        end else begin
            for (int i = 0; i < NREQ; i++) if (prev_clr[i]) m_sticky[i] = 8'h00;
            if (sb.size() > 0 && sb[0].due == s) begin
                e  = sb.pop_front();
                oh = NREQ'(1) << e.id;
                rsp_now = 1'b1;
                chk("rsp_valid", 64'(rsp_valid), 64'(oh));
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
                chk("rsp_flags", 64'(rsp_flags), 64'(e.flags));
                m_sticky[e.id] = m_sticky[e.id] | e.flags;
                m_last_data = e.data; m_last_flags = e.flags;
                $display("step %0d rsp id=%0d data=%h flags=%h", s, e.id, rsp_data, rsp_flags);
            end else begin
                chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
                chk("rsp_data_hold", 64'(rsp_data), 64'(m_last_data));
                chk("rsp_flags_hold", 64'(rsp_flags), 64'(m_last_flags));
            end
        end
        for (int i = 0; i < NREQ; i++) chk("sticky", 64'(sticky_flags[8*i +: 8]), 64'(m_sticky[i]));
        chk("busy", 64'(busy), 64'((sb.size() > 0) || rsp_now));
    endtask

    task automatic drive();
        logic [NREQ-1:0] eg, hs;
        int gid, idx;
        op_t o;
        logic [39:0] r;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = pend[i].size() > 0;
            o = '{32'd0, 32'd0, 3'd0, 2'd0};
            if (pend[i].size() > 0) o = pend[i][0];
            req_opa[32*i +: 32] = o.opa;
            req_opb[32*i +: 32] = o.opb;
            req_op[3*i +: 3]    = o.op;
            req_rmode[2*i +: 2] = o.rm;
        end
        rst = tb_rst; en = tb_en; flag_clr = tb_clr;
        #1;
        eg = '0; gid = -1;
        if (!tb_rst && tb_en) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (gid < 0 && pend[idx].size() > 0 && pend[idx][0].op <= 3'd3) gid = idx;
            end
        end
        if (gid >= 0) eg[gid] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(eg));
        if (gid >= 0) m_ptr = (gid + 1) % NREQ;
        if (tb_rst) m_ptr = 0;
        hs = req_valid & req_ready;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) begin
                o = pend[i].pop_front();
                r = core_fn(o.opa, o.opb, o.op, o.rm);
                // Handshake precedes edge T; response is visible after edge T+LAT+1.
                sb.push_back('{i, r[31:0], r[39:32], s + LAT + 2});
                grant_log.push_back(i);
                hs_count++; last_hs_step = s;
                $display("step %0d issue id=%0d opa=%h opb=%h op=%0d", s, i, o.opa, o.opb, o.op);
                break;
            end
        end
        prev_rst = tb_rst; prev_clr = tb_clr;
        s++;
    endtask

    task automatic step();
        @(negedge clk);
        if (s > 0) check_rsp();
        drive();
    endtask

    task automatic run_idle(input string name);
        int n;
        n = 0;
        while ((sb.size() > 0 || pend[0].size() > 0 || pend[1].size() > 0 ||
                pend[2].size() > 0 || pend[3].size() > 0) && n < 300) begin
            step(); n++;
        end
        if (n >= 300) fail_bound(name);
        step();
    endtask

    function automatic op_t to_op(input vec_t v);
        return '{v.opa, v.opb, v.op, v.rm};
    endfunction

    initial begin
        int c, n, base;
        for (int i = 0; i < NREQ; i++) m_sticky[i] = 8'h00;
        req_valid = '0; req_opa = '0; req_opb = '0; req_op = '0; req_rmode = '0;
        rst = 1'b1; en = 1'b1; flag_clr = '0;

        vecs[0]  = '{0, 32'h3F800000, 32'h40000000, 3'd0, 2'd0};
        vecs[1]  = '{0, 32'h11112222, 32'h33330001, 3'd1, 2'd1};
        vecs[2]  = '{1, 32'hA5A5A5A5, 32'h0F0F0002, 3'd2, 2'd2};
        vecs[3]  = '{2, 32'h12345678, 32'h9ABC0000, 3'd3, 2'd3};
        vecs[4]  = '{3, 32'hDEADBEEF, 32'hCAFE0008, 3'd0, 2'd0};
        vecs[5]  = '{0, 32'h01020304, 32'h05060740, 3'd2, 2'd1};
        vecs[6]  = '{1, 32'hFFFF0000, 32'h0000FF04, 3'd1, 2'd3};
        vecs[7]  = '{2, 32'h80000000, 32'h7FFFFF00, 3'd3, 2'd0};
        vecs[8]  = '{3, 32'h00000001, 32'h00000080, 3'd0, 2'd2};
        vecs[9]  = '{2, 32'h7F800000, 32'h7FC00000, 3'd0, 2'd0};
        vecs[10] = '{1, 32'h12341234, 32'h56780001, 3'd2, 2'd0};
        vecs[11] = '{1, 32'h0BADF00D, 32'h9ABC0010, 3'd1, 2'd1};

        // Reset state
        repeat (3) step();
        chk("rst_fpu_opa", 64'(fpu_opa), 64'd0);
        chk("rst_fpu_opb", 64'(fpu_opb), 64'd0);
        chk("rst_fpu_op", 64'(fpu_op), 64'd0);
        chk("rst_fpu_rmode", 64'(fpu_rmode), 64'd0);
        tb_rst = 1'b0;

        // 1: single add 1.0 + 2.0
        pend[0].push_back(to_op(vecs[0]));
        run_idle("t1_drain");

        // 2: all requesters busy, one grant per cycle in rotating order
        base = grant_log.size();
        for (int i = 1; i <= 8; i++) pend[vecs[i].req].push_back(to_op(vecs[i]));
        run_idle("t2_drain");
        for (int i = 0; i < 8; i++) chk("t2_order", 64'(grant_log[base + i]), 64'((1 + i) % NREQ));

        // 3: inf op qnan on requester 2; sticky holds until cleared
        tb_clr = 4'b0100; step(); tb_clr = '0;
        pend[2].push_back(to_op(vecs[9]));
        run_idle("t3_drain");
        chk("t3_sticky2", 64'(sticky_flags[23:16]), 64'h0A0);
        repeat (3) step();
        chk("t3_sticky2_hold", 64'(sticky_flags[23:16]), 64'h0A0);
        tb_clr = 4'b0100; step(); tb_clr = '0; step();
        chk("t3_sticky2_clr", 64'(sticky_flags[23:16]), 64'h0);

        // 4: clear and set on the same edge, new flags survive
        pend[1].push_back(to_op(vecs[10]));
        run_idle("t4a_drain");
        pend[1].push_back(to_op(vecs[11]));
        c = hs_count; n = 0;
        while (hs_count == c && n < 20) begin step(); n++; end
        if (n >= 20) fail_bound("t4_issue");
        c = last_hs_step;
        while (s < c + LAT + 1) step();
        tb_clr = 4'b0010; step(); tb_clr = '0; step();
        chk("t4_sticky1", 64'(sticky_flags[15:8]), 64'h10);
        run_idle("t4_drain");

        // 5: reset one cycle after the third issue kills all in-flight ops
        for (int i = 1; i <= 3; i++) pend[0].push_back(to_op(vecs[i]));
        c = hs_count; n = 0;
        while (hs_count < c + 3 && n < 20) begin step(); n++; end
        if (n >= 20) fail_bound("t5_issue");
        tb_rst = 1'b1; step(); tb_rst = 1'b0;
        repeat (10) step();
        chk("t5_busy", 64'(busy), 64'd0);
        base = grant_log.size();
        for (int i = 1; i <= 4; i++) pend[vecs[i].req].push_back(to_op(vecs[i]));
        run_idle("t5_drain");
        chk("t5_first_grant", 64'(grant_log[base]), 64'd0);

        // 6: en low blocks grants; illegal op on requester 1 stalls only it
        tb_en = 1'b0;
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < 3; j++) pend[i].push_back(to_op(vecs[1 + ((i + j) % 8)]));
        pend[1][0].op = 3'd5;
        repeat (5) step();
        chk("t6_ready_en0", 64'(req_ready), 64'd0);
        tb_en = 1'b1;
        repeat (14) step();
        chk("t6_req1_stalled", 64'(pend[1].size()), 64'd3);
        pend[1].delete();
        run_idle("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
